nios2_onchip_mem_arbiter: RTL and testbench
===========================================

Name: nios2_onchip_mem_arbiter

Overview:
- Shares one single-port on-chip RAM (32-bit data, 13-bit word address, 4 byte enables, 1-cycle read latency) between two Avalon-MM requesters.
- Typical requesters are the Nios II data master (m0) and a DMA master (m1).
- Grants at most one transfer per cycle and drives the RAM's port directly.
- Returns read data with readdatavalid to the master that issued the read.

Parameters:
- ADDR_W, 13, word address width of the RAM and both masters.
- DATA_W, 32, data width.
- BE_W, 4, byte-enable width (DATA_W/8).
- MAX_HOLD, 4, maximum consecutive grants to one master while the other is requesting (range 1..15).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  BE_W  byte lanes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_W  read data
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid
- mem_address  out  ADDR_W  RAM address
- mem_byteenable  out  BE_W  RAM byte enables
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write strobe
- mem_writedata  out  DATA_W  RAM write data
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  DATA_W  RAM read data, valid the cycle after the address is presented

Behaviour:
- Clock and reset: one clock domain (clk). reset_n is asynchronous assert, synchronous deassert; it is synchronised externally.
- Reset values:
  - owner = NONE, hold_cnt = 0.
  - rd_pend = 0, rd_src = 0.
  - Both readdatavalid = 0; both waitrequest = 1.
  - mem_chipselect = 0, mem_write = 0, mem_clken = 0.
- Request: req_i = mi_read | mi_write. If read and write are both asserted, the write wins and the read is dropped; a simulation assertion flags this.
- Grant FSM, states NONE / OWN0 / OWN1, evaluated combinationally from requests and registered state:
  - Neither master requesting: no grant; next state NONE; hold_cnt = 0.
  - Exactly one master requesting: grant it; next state OWNi. hold_cnt = 1 if ownership changes, otherwise saturating +1.
  - Both requesting, state NONE: grant m0.
  - Both requesting, state OWNi with hold_cnt < MAX_HOLD: grant mi again and increment hold_cnt.
  - Both requesting, state OWNi with hold_cnt == MAX_HOLD: grant the other master; hold_cnt = 1.
- Granted master: waitrequest = 0 in the same cycle. mem_* are a combinational mux of its signals; mem_chipselect = 1; mem_write = its write.
- Non-granted master: waitrequest = 1.
- mem_clken = 1 whenever out of reset.
- Read return:
  - A granted read sets rd_pend = 1 and rd_src = i at the clock edge.
  - In the next cycle, the rd_src master sees readdatavalid = 1 and readdata = mem_readdata.
  - Fixed latency of 1; back-to-back reads sustain 1 per cycle.
  - Switching masters between consecutive reads causes no bubble.
- The non-selected readdata output is held at 0.
- Write followed by a read of the same address in the next cycle returns the new data, because RAM accesses are ordered by grant.
- Reset mid-read: rd_pend clears immediately, and no readdatavalid is produced for the lost read.
- Throughput: one transfer per cycle, 100 % utilisation under contention.

Optional Feature:
- Macro: NIOS2_MEM_ARB_FIXED_PRIO_EN.
- Defined: m0 always wins under contention; hold_cnt and MAX_HOLD are unused, and m1 is granted only when m0 is idle.
- Undefined: the MAX_HOLD round-robin fairness described above.

Decomposition:
- Package nios2_mem_arb_pkg: owner enum (NONE, OWN0, OWN1); constants ARB_ADDR_W = 13, ARB_DATA_W = 32, ARB_BE_W = 4; hold counter width 4.
- Sub-module nios2_mem_arb_grant: grant FSM plus hold counter. Inputs are req0 and req1; outputs are gnt0, gnt1 and the registered owner.
- The top level keeps the datapath mux and the read-return tracking.

Test Plan:
- Reset: hold reset_n = 0 with both masters requesting → both waitrequest = 1, mem_chipselect = 0, readdatavalid = 0. After release, m0 is granted first.
- m0 only: write 0xDEADBEEF to address 0x0010 with byteenable 0xF, then read 0x0010 → waitrequest = 0 both cycles, m0_readdatavalid = 1 one cycle after the read with data 0xDEADBEEF.
- Byte lanes: m1 writes 0x000000AA to 0x0020 with byteenable 0x1 over a preload of 0x11223344, then reads → 0x112233AA on m1 only; m0_readdatavalid stays 0.
- Contention, MAX_HOLD = 4: both issue continuous reads → grant pattern m0×4, m1×4, m0×4. Each readdatavalid routes to the issuer; no idle cycles on mem_chipselect.
- Reset mid-operation: assert reset_n = 0 in the cycle after a granted m1 read → m1_readdatavalid never asserts and the FSM returns to NONE.
- With NIOS2_MEM_ARB_FIXED_PRIO_EN: both masters request for 10 cycles → m0 granted all 10 and m1_waitrequest = 1 throughout. m1 is granted in the first cycle m0 drops its request.

Source files
------------

// File: rtl/nios2_mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// nios2_mem_arb_pkg
// Shared types and constants for the two-master on-chip RAM arbiter.
//   owner_e    : which master the arbiter granted last (NONE / OWN0 / OWN1)
//   ARB_*      : default address / data / byte-enable widths
//   HOLD_W     : width of the consecutive-grant (fairness) counter
// ---------------------------------------------------------------------------
package nios2_mem_arb_pkg;

  localparam int ARB_ADDR_W = 13;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = 4;
  localparam int HOLD_W     = 4;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

endpackage

// File: rtl/nios2_mem_arb_grant.sv
// ---------------------------------------------------------------------------
// nios2_mem_arb_grant
// Grant FSM for two requesters. The grant is combinational from the current
// requests and the registered owner / hold counter, so a granted master sees
// waitrequest drop in the same cycle it asks.
//
// Default build: round-robin with a hold limit. A master keeps the RAM for up
// to MAX_HOLD consecutive grants while the other one is also requesting.
// With NIOS2_MEM_ARB_FIXED_PRIO_EN defined: m0 always wins; m1 is granted only
// when m0 is idle, and the hold counter stays at zero.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   req0, req1   : requests from master 0 / master 1
//   gnt0, gnt1   : one-hot (or zero) grant for this cycle
//   owner        : registered owner of the last granted transfer
// ---------------------------------------------------------------------------
module nios2_mem_arb_grant
  import nios2_mem_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   req0,
  input  logic   req1,
  output logic   gnt0,
  output logic   gnt1,
  output owner_e owner
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  owner_e            owner_nxt;

  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] h);
    return (h == '1) ? h : h + HOLD_ONE;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case/if tree can leave a value unassigned (no latch).
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    owner_nxt = NONE;
    hold_nxt  = '0;
`ifdef NIOS2_MEM_ARB_FIXED_PRIO_EN
    if (req0) begin
      gnt0      = 1'b1;
      owner_nxt = OWN0;
    end else if (req1) begin
      gnt1      = 1'b1;
      owner_nxt = OWN1;
    end
`else
    unique case ({req1, req0})
      2'b01: begin
        gnt0      = 1'b1;
        owner_nxt = OWN0;
        hold_nxt  = (owner == OWN0) ? sat_inc(hold_cnt) : HOLD_ONE;
      end
      2'b10: begin
        gnt1      = 1'b1;
        owner_nxt = OWN1;
        hold_nxt  = (owner == OWN1) ? sat_inc(hold_cnt) : HOLD_ONE;
      end
      2'b11: begin
        // Contention: stay with the current owner until it has used its
        // MAX_HOLD slots, then hand over. From NONE, m0 goes first.
        if (owner == OWN1 && hold_cnt < HOLD_MAX) begin
          gnt1      = 1'b1;
          owner_nxt = OWN1;
          hold_nxt  = sat_inc(hold_cnt);
        end else if (owner == OWN0 && hold_cnt < HOLD_MAX) begin
          gnt0      = 1'b1;
          owner_nxt = OWN0;
          hold_nxt  = sat_inc(hold_cnt);
        end else if (owner == OWN0) begin
          gnt1      = 1'b1;
          owner_nxt = OWN1;
          hold_nxt  = HOLD_ONE;
        end else begin
          gnt0      = 1'b1;
          owner_nxt = OWN0;
          hold_nxt  = HOLD_ONE;
        end
      end
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner    <= NONE;
      hold_cnt <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
    end
  end

endmodule

// File: rtl/nios2_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// nios2_onchip_mem_arbiter
// Shares one single-port on-chip RAM (1-cycle read latency) between two
// Avalon-MM masters (typically Nios II data master on m0, DMA on m1).
// At most one transfer is granted per cycle; the granted master's signals
// are muxed straight onto the RAM port, and read data is steered back to the
// master that issued the read one cycle later.
//
// Build option: NIOS2_MEM_ARB_FIXED_PRIO_EN selects fixed m0 priority instead
// of MAX_HOLD round-robin fairness.
//
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   m{0,1}_address/byteenable/read/write/writedata : master requests
//   m{0,1}_waitrequest      : request not accepted this cycle
//   m{0,1}_readdata/readdatavalid : read return (readdata is 0 when not valid)
//   mem_address/byteenable/chipselect/write/writedata/clken : RAM port
//   mem_readdata            : RAM read data, valid the cycle after the address
// ---------------------------------------------------------------------------
module nios2_onchip_mem_arbiter
  import nios2_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int DATA_W   = ARB_DATA_W,
  parameter int BE_W     = ARB_BE_W,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic   req0, req1;
  logic   gnt0, gnt1;
  logic   rd_go;
  logic   rd_pend;
  logic   rd_src;
  owner_e owner;

  // Requests are masked while reset is asserted so nothing is granted
  // (waitrequest high, chipselect low) even though the grant is combinational.
  assign req0 = (m0_read | m0_write) & reset_n;
  assign req1 = (m1_read | m1_write) & reset_n;

  nios2_mem_arb_grant #(
    .MAX_HOLD (MAX_HOLD)
  ) u_grant (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .req1    (req1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .owner   (owner)
  );

  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  // Datapath mux: m1 only when it holds the grant, otherwise m0's signals
  // pass through (qualified by chipselect).
  assign mem_address    = gnt1 ? m1_address    : m0_address;
  assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
  assign mem_write      = gnt1 ? m1_write      : (gnt0 & m0_write);
  assign mem_chipselect = gnt0 | gnt1;
  assign mem_clken      = reset_n;

  // A read accompanied by a write is dropped: the write wins.
  assign rd_go = gnt1 ? (m1_read & ~m1_write) : (gnt0 & m0_read & ~m0_write);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend <= 1'b0;
      rd_src  <= 1'b0;
    end else begin
      rd_pend <= rd_go;
      rd_src  <= gnt1;
    end
  end

  assign m0_readdatavalid = rd_pend & ~rd_src;
  assign m1_readdatavalid = rd_pend &  rd_src;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

`ifndef SYNTHESIS
  a_m0_rw_excl : assert property (@(posedge clk) disable iff (!reset_n)
                                  !(m0_read && m0_write))
    else $warning("m0 asserted read and write together; read dropped");
  a_m1_rw_excl : assert property (@(posedge clk) disable iff (!reset_n)
                                  !(m1_read && m1_write))
    else $warning("m1 asserted read and write together; read dropped");
`endif

endmodule

// File: tb/tb_nios2_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nios2_onchip_mem_arbiter
// Directed bench for nios2_onchip_mem_arbiter with a behavioural 1-cycle RAM.
// Stimulus pushes expected read returns into a scoreboard queue; a monitor
// pops and compares on every readdatavalid. Grant behaviour is checked
// in-line against hand-derived patterns. Honours NIOS2_MEM_ARB_FIXED_PRIO_EN.
// ---------------------------------------------------------------------------
module tb_nios2_onchip_mem_arbiter;
  import nios2_mem_arb_pkg::*;

  typedef struct {
    logic        src;
    logic [31:0] data;
  } rd_exp_t;

  logic        clk;
  logic        reset_n;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  int tests_run = 0;
  int tests_failed = 0;
  rd_exp_t sb[$];

  logic [31:0] ram [0:8191];

  nios2_onchip_mem_arbiter #(.MAX_HOLD(4)) u_dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM, registered read data.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every readdatavalid must match the oldest expectation.
  always @(negedge clk) begin
    if (m0_readdatavalid || m1_readdatavalid) begin
      if (sb.size() == 0) begin
        check("unexpected_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
      end else begin
        rd_exp_t e;
        e = sb.pop_front();
        check("rdv_m0", {31'd0, m0_readdatavalid}, {31'd0, ~e.src});
        check("rdv_m1", {31'd0, m1_readdatavalid}, {31'd0, e.src});
        check("rd_data", e.src ? m1_readdata : m0_readdata, e.data);
        check("rd_other_zero", e.src ? m0_readdata : m1_readdata, 32'd0);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic all_idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_address = '0; m1_address = '0;
    m0_writedata = '0; m1_writedata = '0;
  endtask

  task automatic check_grant(input string name, input logic g0, input logic g1);
    check({name, "_gnt0"}, {31'd0, ~m0_waitrequest}, {31'd0, g0});
    check({name, "_gnt1"}, {31'd0, ~m1_waitrequest}, {31'd0, g1});
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) ram[a] = 32'hC0DE_0000 | a;
    ram[13'h020] = 32'h1122_3344;
    mem_readdata = '0;
    all_idle();

    // --- Reset with both masters requesting --------------------------------
    reset_n = 1'b0;
    m0_write = 1; m0_address = 13'h300; m0_writedata = 32'h0000_0300;
    m1_write = 1; m1_address = 13'h301; m1_writedata = 32'h0000_0301;
    @(negedge clk);
    check_grant("rst", 1'b0, 1'b0);
    check("rst_cs", {31'd0, mem_chipselect}, 32'd0);
    check("rst_clken", {31'd0, mem_clken}, 32'd0);
    check("rst_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_grant("rel", 1'b1, 1'b0);
    check("rel_clken", {31'd0, mem_clken}, 32'd1);
    next_cycle();
    all_idle();
    next_cycle();

    // --- m0 only: write then read the same word ----------------------------
    m0_write = 1; m0_address = 13'h010; m0_writedata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_grant("m0_wr", 1'b1, 1'b0);
    check("m0_wr_memwr", {31'd0, mem_write}, 32'd1);
    check("m0_wr_addr", {19'd0, mem_address}, 32'h010);
    next_cycle();
    m0_write = 0; m0_read = 1;
    @(negedge clk);
    check_grant("m0_rd", 1'b1, 1'b0);
    check("m0_rd_memwr", {31'd0, mem_write}, 32'd0);
    sb.push_back('{src: 1'b0, data: 32'hDEAD_BEEF});
    next_cycle();
    all_idle();
    next_cycle();

    // --- m1 byte-lane write over preload, then read ------------------------
    m1_write = 1; m1_address = 13'h020; m1_byteenable = 4'h1; m1_writedata = 32'h0000_00AA;
    @(negedge clk);
    check_grant("m1_wr", 1'b0, 1'b1);
    check("m1_wr_be", {28'd0, mem_byteenable}, 32'h1);
    next_cycle();
    m1_write = 0; m1_read = 1; m1_byteenable = 4'hF;
    @(negedge clk);
    check_grant("m1_rd", 1'b0, 1'b1);
    sb.push_back('{src: 1'b1, data: 32'h1122_33AA});
    next_cycle();
    all_idle();
    next_cycle();

    // --- Contention with continuous reads ----------------------------------
    m0_read = 1; m0_address = 13'h100;
    m1_read = 1; m1_address = 13'h200;
`ifdef NIOS2_MEM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_grant($sformatf("fp%0d", k), 1'b1, 1'b0);
      sb.push_back('{src: 1'b0, data: 32'hC0DE_0100});
      next_cycle();
    end
    m0_read = 0;
    @(negedge clk);
    check_grant("fp_handover", 1'b0, 1'b1);
    sb.push_back('{src: 1'b1, data: 32'hC0DE_0200});
    next_cycle();
`else
    for (int k = 0; k < 12; k++) begin
      logic g0;
      g0 = (k < 4) || (k >= 8);
      @(negedge clk);
      check_grant($sformatf("rr%0d", k), g0, ~g0);
      check($sformatf("rr%0d_cs", k), {31'd0, mem_chipselect}, 32'd1);
      sb.push_back('{src: ~g0, data: g0 ? 32'hC0DE_0100 : 32'hC0DE_0200});
      next_cycle();
    end
`endif
    all_idle();
    next_cycle();
    next_cycle();

    // --- Reset in the cycle after a granted m1 read ------------------------
    m1_read = 1; m1_address = 13'h200;
    @(negedge clk);
    check_grant("mid_rd", 1'b0, 1'b1);
    next_cycle();
    all_idle();
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    check("mid_rst_owner", {30'd0, u_dut.u_grant.owner}, {30'd0, NONE});
    next_cycle();
    reset_n = 1'b1;
    m0_write = 1; m0_address = 13'h300; m0_writedata = 32'h1;
    m1_write = 1; m1_address = 13'h301; m1_writedata = 32'h2;
    @(negedge clk);
    check_grant("post_rst", 1'b1, 1'b0);
    next_cycle();
    all_idle();

    for (int i = 0; i < 3; i++) next_cycle();
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
